mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory of the multi-cycle CPU between two requesters: the core (fetch, memread, memwrite states) and the program loader/debug port.
- Sits between the core's memory interface (address from the AdrSrc mux) and the memory macro. Handles a variable-latency memory acknowledge.
- Applies round-robin arbitration, a loader lock, and a timeout watchdog.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_timeout_ctr.sv | 29 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and reset values for the memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } arbstate;

  typedef enum logic {
    G_CORE,
    G_LOADER
  } granttype;

  // Loader counts as the previous winner out of reset so the core takes the first tie.
  localparam arbstate  RST_STATE      = S_IDLE;
  localparam granttype RST_LAST_GRANT = G_LOADER;
  localparam logic     RST_FLAG       = 1'b0;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Watchdog for one memory transaction: counts busy cycles, flags the last allowed one.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Count up while enabled, holding at the terminal value until cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU core and the loader.
//
// state  | meaning
// S_IDLE | no transfer; pick a winner among eligible requesters
// S_BUSY | mem_req held with a stable payload, waiting for mem_ack or timeout
// S_RESP | winner's ack (and err on timeout) is high for this one cycle
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              err_sticky
);

  arbstate  state, state_nxt;
  granttype last_grant;
  logic     core_elig, ld_elig, pick_loader, any_req, expired, finish;

  assign core_elig   = core_req && !ld_lock;
  assign ld_elig     = ld_req;
  assign any_req     = core_elig || ld_elig;
  assign pick_loader = ld_elig && (!core_elig || (last_grant == G_CORE));
  assign finish      = mem_ack || expired;

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != S_BUSY),
    .enable  (state == S_BUSY),
    .expired (expired)
  );

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_BUSY;
      S_BUSY:  if (finish) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RST_STATE;
    else          state <= state_nxt;
  end

  // Registered outputs; last_grant doubles as the owner of the transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= RST_LAST_GRANT;
      mem_req    <= RST_FLAG;
      mem_we     <= RST_FLAG;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_ack   <= RST_FLAG;
      core_rdata <= '0;
      ld_ack     <= RST_FLAG;
      ld_rdata   <= '0;
      err        <= RST_FLAG;
      err_sticky <= RST_FLAG;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            mem_req <= 1'b1;
            if (pick_loader) begin
              last_grant <= G_LOADER;
              mem_we     <= ld_we;
              mem_addr   <= ld_addr;
              mem_wdata  <= ld_wdata;
            end else begin
              last_grant <= G_CORE;
              mem_we     <= core_we;
              mem_addr   <= core_addr;
              mem_wdata  <= core_wdata;
            end
          end
        end
        S_BUSY: begin
          if (finish) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            // A real acknowledge beats a coincident timeout.
            err     <= !mem_ack;
            if (!mem_ack) err_sticky <= 1'b1;
            if (last_grant == G_CORE) begin
              core_ack   <= 1'b1;
              core_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              ld_ack     <= 1'b1;
              ld_rdata   <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        S_RESP: begin
          core_ack <= 1'b0;
          ld_ack   <= 1'b0;
          err      <= 1'b0;
        end
        default: begin
          core_ack <= 1'b0;
          ld_ack   <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          core_req, core_we, core_ack;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          ld_req, ld_we, ld_lock, ld_ack;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          err, err_sticky;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_lock(ld_lock), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .err_sticky(err_sticky)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- memory responder ----------------
  int ack_delay = 2;
  int hi_cnt = 0;
  bit stray = 1'b0;
  logic [DW-1:0] rd_base = '0;

  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req) hi_cnt++;
      else hi_cnt = 0;
      mem_rdata = rd_base + mem_addr;
      mem_ack = (mem_req && hi_cnt == ack_delay + 1) || stray;
    end
  end

  // ---------------- requesters ----------------
  int core_done = 0, core_target = 0;
  int ld_done = 0, ld_target = 0;
  logic [AW-1:0] core_base = 32'h10;
  logic [AW-1:0] ld_base = 32'h200;

  initial begin
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (core_ack) core_done++;
      core_req   = core_done < core_target;
      core_we    = (core_done % 2) == 1;
      core_addr  = core_base + 32'(core_done * 4);
      core_wdata = 32'hC0DE_0000 + 32'(core_done);
    end
  end

  initial begin
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (ld_ack) ld_done++;
      ld_req   = ld_done < ld_target;
      ld_we    = (ld_done % 2) == 0;
      ld_addr  = ld_base + 32'(ld_done * 4);
      ld_wdata = 32'h10AD_0000 + 32'(ld_done);
    end
  end

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 memory owned by a requester, 2 answering the requester
  int m_phase, m_owner, m_last, m_wait;
  bit m_ce, m_le;
  logic m_mem_req, m_mem_we, m_core_ack, m_ld_ack, m_err, m_sticky;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_core_rd, m_ld_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_owner = 0; m_last = 1; m_wait = 0;
      m_mem_req = 0; m_mem_we = 0; m_core_ack = 0; m_ld_ack = 0;
      m_err = 0; m_sticky = 0; m_addr = '0; m_wdata = '0;
      m_core_rd = '0; m_ld_rd = '0;
    end else begin
      case (m_phase)
        0: begin
          m_ce = core_req && !ld_lock;
          m_le = ld_req;
          if (m_ce || m_le) begin
            if (m_ce && m_le) m_owner = 1 - m_last;
            else m_owner = m_ce ? 0 : 1;
            m_last = m_owner;
            if (m_owner == 0) begin
              m_mem_we = core_we; m_addr = core_addr; m_wdata = core_wdata;
            end else begin
              m_mem_we = ld_we; m_addr = ld_addr; m_wdata = ld_wdata;
            end
            m_mem_req = 1; m_wait = 0; m_phase = 1;
          end
        end
        1: begin
          m_wait = m_wait + 1;
          if (mem_ack || m_wait == TO) begin
            m_mem_req = 0; m_mem_we = 0; m_phase = 2;
            m_err = !mem_ack;
            if (!mem_ack) m_sticky = 1;
            if (m_owner == 0) begin
              m_core_ack = 1; m_core_rd = mem_ack ? mem_rdata : '0;
            end else begin
              m_ld_ack = 1; m_ld_rd = mem_ack ? mem_rdata : '0;
            end
          end
        end
        default: begin
          m_core_ack = 0; m_ld_ack = 0; m_err = 0; m_phase = 0;
        end
      endcase
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    chk("mem_req", mem_req, m_mem_req);
    chk("mem_we", mem_we, m_mem_we);
    if (m_mem_req) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("core_ack", core_ack, m_core_ack);
    chk("ld_ack", ld_ack, m_ld_ack);
    chk("core_rdata", core_rdata, m_core_rd);
    chk("ld_rdata", ld_rdata, m_ld_rd);
    chk("err", err, m_err);
    chk("err_sticky", err_sticky, m_sticky);
  end

  // ---------------- observation log ----------------
  int glog[$];
  bit prev_req = 0;
  int req_len = 0, last_len = 0, mack_cyc = 0, last_lat = 0, ld_acks = 0;
  bit last_err = 0;
  logic [DW-1:0] last_core_rd = '0;

  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      glog.push_back((mem_addr < 32'h200) ? 0 : 1);
      req_len = 0;
    end
    if (mem_req) req_len++;
    if (!mem_req && prev_req) last_len = req_len;
    prev_req = mem_req;
    if (mem_ack) mack_cyc = cyc;
    if (core_ack) begin
      last_lat = cyc - mack_cyc;
      last_err = err;
      last_core_rd = core_rdata;
    end
    if (ld_ack) ld_acks++;
  end

  task automatic wait_done(string name, int budget);
    int n = 0;
    while ((core_done < core_target || ld_done < ld_target) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_in_time"}, n < budget, 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int idx;
    int ld_start;
    ld_lock = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_core_ack", core_ack, 0);
    chk("rst_sticky", err_sticky, 0);
    @(negedge clk);
    reset_n = 1;

    // T1: single core read, memory answers 3 cycles after mem_req
    rd_base = 32'hDEADBEEF - 32'h10;
    ack_delay = 3;
    ld_acks = 0;
    glog.delete();
    core_target = 1;
    wait_done("t1", 60);
    chk("t1_rdata", core_rdata, 32'hDEADBEEF);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_ack_lat", last_lat, 1);
    chk("t1_ld_ack", ld_acks, 0);
    chk("t1_ngrants", glog.size(), 1);

    // T2: both requesting from reset -> core, loader, core, loader
    do_reset();
    core_base = 32'h100;
    ld_base = 32'h200;
    rd_base = 32'h5000_0000;
    ack_delay = 1;
    glog.delete();
    core_target = core_done + 2;
    ld_target = ld_done + 2;
    wait_done("t2", 100);
    chk("t2_ngrants", glog.size(), 4);
    if (glog.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), glog[i], i % 2);

    // T3: lock keeps the core out; release lets it in at the next idle
    glog.delete();
    ld_lock = 1;
    ld_start = ld_done;
    core_target = core_done + 2;
    ld_target = ld_done + 4;
    n = 0;
    while (ld_done < ld_start + 2 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("t3_lock_phase", n < 200, 1);
    ld_lock = 0;
    wait_done("t3", 200);
    chk("t3_ngrants", glog.size(), 6);
    if (glog.size() >= 6) begin
      chk("t3_grant0", glog[0], 1);
      chk("t3_grant1", glog[1], 1);
      chk("t3_grant2", glog[2], 0);
      chk("t3_grant3", glog[3], 1);
      chk("t3_grant4", glog[4], 0);
    end

    // T3b: lock raised while the core owns memory does not abort it
    ack_delay = 6;
    core_target = core_done + 1;
    n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    ld_lock = 1;
    wait_done("t3b", 60);
    ld_lock = 0;

    // Stray acknowledge while idle must be ignored
    stray = 1;
    repeat (2) @(posedge clk);
    #2;
    stray = 0;
    repeat (2) @(posedge clk);
    #2;

    // T4: memory never answers -> timeout after TIMEOUT cycles of mem_req
    ack_delay = 1000;
    core_target = core_done + 1;
    wait_done("t4", 100);
    chk("t4_req_len", last_len, 16);
    chk("t4_err", last_err, 1);
    chk("t4_rdata", last_core_rd, 0);
    chk("t4_sticky", err_sticky, 1);

    // T5: ack in the timeout cycle wins, no error
    ack_delay = 15;
    rd_base = 32'h1234_0000;
    idx = core_done;
    core_target = core_done + 1;
    wait_done("t5", 100);
    chk("t5_req_len", last_len, 16);
    chk("t5_err", last_err, 0);
    chk("t5_rdata", last_core_rd, 32'h1234_0000 + 32'h100 + 32'(idx * 4));
    chk("t5_sticky_held", err_sticky, 1);

    // T6: reset during a transfer, then core wins the retry
    ack_delay = 1000;
    core_target = core_done + 1;
    ld_target = ld_done + 1;
    n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    idx = core_done;
    ld_start = ld_done;
    reset_n = 0;
    #1;
    chk("t6_async_drop", mem_req, 0);
    chk("t6_sticky_clr", err_sticky, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    chk("t6_no_core_ack", core_done, idx);
    chk("t6_no_ld_ack", ld_done, ld_start);
    ack_delay = 2;
    glog.delete();
    wait_done("t6", 100);
    chk("t6_ngrants", glog.size(), 2);
    if (glog.size() >= 1) chk("t6_first_core", glog[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
